parking_request_issuer: RTL and testbench
=========================================

// Module: parking_request_issuer
// PURPOSE
//  Request-side initiator for parking_lot_top. Accepts queued car/leakage requests over a
//  valid/ready handshake and buffers them in a FIFO. Replays them onto the lot's input bus as
//  one-cycle in_mode/out_mode pulses with a fixed minimum spacing.
//  Holds leakage/leakage_floor as levels. Sits between the operator front-end and parking_lot_top.
// PARAMETERS
//  DEPTH       4   FIFO entries (power of 2, >=2)
//  GAP_CYCLES  6   idle cycles forced after every in/out pulse (>=1)
// PORTS
//  clock          in   1   system clock, rising edge
//  reset_n        in   1   asynchronous, active-low reset
//  req_valid      in   1   upstream request present
//  req_ready      out  1   FIFO can accept (= !full, registered)
//  req_kind       in   2   0=IN, 1=OUT, 2=LEAK_ON, 3=LEAK_OFF
//  req_plate      in   16  4 BCD digits; used for IN/OUT only
//  req_floor      in   3   leak floor 1..7; used for LEAK_ON only
//  hold           in   1   downstream stall; blocks any pop while high
//  license_plate  out  16  plate shown during the pulse cycle, else 0
//  in_mode        out  1   one-cycle entry pulse
//  out_mode       out  1   one-cycle exit pulse
//  leakage        out  1   leak level
//  leakage_floor  out  3   leak floor level
//  err_pulse      out  1   one cycle high when a request is dropped as invalid
//  issued_cnt     out  8   pulses issued, wraps 255->0
//  dropped_cnt    out  8   invalid requests dropped, saturates at 255
// BEHAVIOUR
//  - Reset (async, reset_n=0): FIFO empty; req_ready=1; all other outputs 0; FSM=IDLE.
//    Reset mid-pulse or mid-gap aborts immediately and discards queued requests.
//  - Push: on the edge where req_valid&req_ready. When full, req_ready=0 and no push occurs.
//    Push and pop in the same cycle are legal; count stays unchanged.
//  - Entry pushed at edge t0 is poppable at edge t0+1.
//  - FSM IDLE: if FIFO non-empty and hold=0, pop at the edge:
//      IN/OUT with valid plate: load license_plate and in_mode|out_mode; go to ISSUE.
//      IN/OUT with invalid plate (any digit >9, or plate==0): err_pulse next cycle,
//        dropped_cnt+1 (saturating), stay IDLE.
//      LEAK_ON with floor 1..7: leakage=1, leakage_floor=floor, stay IDLE, no gap.
//        floor 0 is invalid: handled as a drop.
//      LEAK_OFF: leakage=0, leakage_floor=0, stay IDLE.
//  - ISSUE lasts exactly 1 cycle. On exit: pulse bits and plate cleared, issued_cnt+1,
//    gap counter=GAP_CYCLES-1, go to GAP.
//  - GAP: counts down while ignoring hold; at 0 go to IDLE.
//  - Timing: min start-to-start spacing of consecutive pulses = GAP_CYCLES+2 cycles.
//  - Leak requests queued behind a pulse take effect only after the gap ends (strict FIFO order).
//  - in_mode and out_mode are never high together. license_plate is nonzero only when one is high.
//  - hold=1 in IDLE: no pop, outputs hold, FIFO may still fill.
// STRUCTURE
//  - parking_pkg:
//      kind codes KIND_IN/OUT/LEAK_ON/LEAK_OFF;
//      state encoding IDLE/ISSUE/GAP;
//      function bcd_plate_valid(16b).
//  - Sub-module request_fifo #(WIDTH=21, DEPTH): synchronous FIFO with registered full/empty,
//    async active-low reset. Issuer holds the FSM, gap counter, output regs and stats counters.
// TESTING
//  1. Reset then push IN 9423 -> in_mode=1 with license_plate=16'h9423 for exactly 1 cycle,
//     2 cycles after accept; issued_cnt=1.
//  2. Push IN 8754 then OUT 8754 back to back, GAP_CYCLES=6 -> the two pulses start
//     exactly 8 cycles apart; out_mode pulse carries 16'h8754.
//  3. Push DEPTH+1 requests with hold=1 -> req_ready drops after the 4th; 5th not accepted.
//     Release hold -> 4 pulses issued in order.
//  4. Push IN 16'h9A23, then LEAK_ON floor 0 -> two err_pulses, dropped_cnt=2,
//     no in_mode, leakage stays 0.
//  5. Push IN 1111, LEAK_ON floor 3 -> leakage=1 and leakage_floor=3 only after the gap ends.
//     LEAK_OFF clears both to 0.
//  6. Assert reset_n=0 during GAP with 2 entries queued -> all outputs 0 asynchronously;
//     no pulses after release.

Source files
------------

// File: rtl/parking_pkg.sv
// Shared types for the parking request issuer: request kinds, FSM encoding,
// the queued request layout and the BCD plate check.
package parking_pkg;

  localparam logic [1:0] KIND_IN       = 2'd0;
  localparam logic [1:0] KIND_OUT      = 2'd1;
  localparam logic [1:0] KIND_LEAK_ON  = 2'd2;
  localparam logic [1:0] KIND_LEAK_OFF = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  typedef struct packed {
    logic [1:0]  kind;
    logic [15:0] plate;
    logic [2:0]  flr;
  } req_t;

  // A plate is usable only if every nibble is a decimal digit and it is not all zeros.
  function automatic logic bcd_plate_valid(input logic [15:0] plate);
    logic ok;
    ok = (plate != 16'h0000);
    for (int i = 0; i < 4; i++) begin
      if (plate[i*4 +: 4] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/request_fifo.sv
// Synchronous FIFO with registered full/empty flags; storage is not reset,
// only the pointers and flags are.
module request_fifo #(
  parameter int WIDTH = 21,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic [AW:0]      count_nxt;
  logic             push_ok;
  logic             pop_ok;

  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    if (push_ok && !pop_ok)      count_nxt = count + 1'b1;
    else if (pop_ok && !push_ok) count_nxt = count - 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
      full  <= (count_nxt == (AW+1)'(DEPTH));
      empty <= (count_nxt == '0);
    end
  end

  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/parking_request_issuer.sv
// Buffers operator requests and replays them to the lot as spaced one-cycle
// in/out pulses, with leak level control and drop/issue statistics.
module parking_request_issuer
  import parking_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int GAP_CYCLES = 6
) (
  input  logic        clock,
  input  logic        reset_n,
  // Handshake: a request is taken on a rising edge where req_valid && req_ready;
  // req_valid may be held or dropped freely while req_ready is low.
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_kind,
  input  logic [15:0] req_plate,
  input  logic [2:0]  req_floor,
  input  logic        hold,
  output logic [15:0] license_plate,
  output logic        in_mode,
  output logic        out_mode,
  output logic        leakage,
  output logic [2:0]  leakage_floor,
  output logic        err_pulse,
  output logic [7:0]  issued_cnt,
  output logic [7:0]  dropped_cnt,
  output state_t      fsm_state
);

  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  state_t        state, state_nxt;
  logic [GW-1:0] gap_cnt, gap_nxt;
  logic [15:0]   plate_nxt;
  logic          in_nxt, out_nxt, leak_nxt, err_nxt;
  logic [2:0]    floor_nxt;
  logic [7:0]    issued_nxt, dropped_nxt;
  logic          full, empty, pop, drop;
  logic [$bits(req_t)-1:0] rdata;
  req_t          head;
  req_t          wreq;

  assign wreq      = '{kind: req_kind, plate: req_plate, flr: req_floor};
  assign head      = req_t'(rdata);
  assign req_ready = !full;
  assign pop       = (state == ST_IDLE) && !empty && !hold;
  assign fsm_state = state;

  request_fifo #(.WIDTH($bits(req_t)), .DEPTH(DEPTH)) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (req_valid),
    .wdata   (wreq),
    .pop     (pop),
    .rdata   (rdata),
    .full    (full),
    .empty   (empty)
  );

  always_comb begin
    state_nxt   = state;
    gap_nxt     = gap_cnt;
    plate_nxt   = license_plate;
    in_nxt      = in_mode;
    out_nxt     = out_mode;
    leak_nxt    = leakage;
    floor_nxt   = leakage_floor;
    err_nxt     = 1'b0;
    issued_nxt  = issued_cnt;
    dropped_nxt = dropped_cnt;
    drop        = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pop) begin
          case (head.kind)
            KIND_IN, KIND_OUT: begin
              if (bcd_plate_valid(head.plate)) begin
                plate_nxt = head.plate;
                in_nxt    = (head.kind == KIND_IN);
                out_nxt   = (head.kind == KIND_OUT);
                state_nxt = ST_ISSUE;
              end else begin
                drop = 1'b1;
              end
            end
            KIND_LEAK_ON: begin
              if (head.flr != 3'd0) begin
                leak_nxt  = 1'b1;
                floor_nxt = head.flr;
              end else begin
                drop = 1'b1;
              end
            end
            default: begin
              leak_nxt  = 1'b0;
              floor_nxt = 3'd0;
            end
          endcase
        end
      end
      ST_ISSUE: begin
        plate_nxt  = 16'h0000;
        in_nxt     = 1'b0;
        out_nxt    = 1'b0;
        issued_nxt = issued_cnt + 8'd1;
        gap_nxt    = GW'(GAP_CYCLES - 1);
        state_nxt  = ST_GAP;
      end
      ST_GAP: begin
        if (gap_cnt == '0) state_nxt = ST_IDLE;
        else               gap_nxt   = gap_cnt - 1'b1;
      end
      default: state_nxt = ST_IDLE;
    endcase
    // Dropped requests flag for one cycle and count with saturation.
    if (drop) begin
      err_nxt = 1'b1;
      if (dropped_cnt != 8'hFF) dropped_nxt = dropped_cnt + 8'd1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      gap_cnt       <= '0;
      license_plate <= 16'h0000;
      in_mode       <= 1'b0;
      out_mode      <= 1'b0;
      leakage       <= 1'b0;
      leakage_floor <= 3'd0;
      err_pulse     <= 1'b0;
      issued_cnt    <= 8'd0;
      dropped_cnt   <= 8'd0;
    end else begin
      state         <= state_nxt;
      gap_cnt       <= gap_nxt;
      license_plate <= plate_nxt;
      in_mode       <= in_nxt;
      out_mode      <= out_nxt;
      leakage       <= leak_nxt;
      leakage_floor <= floor_nxt;
      err_pulse     <= err_nxt;
      issued_cnt    <= issued_nxt;
      dropped_cnt   <= dropped_nxt;
    end
  end

endmodule

// File: tb/tb_parking_request_issuer.sv
// Directed bench for parking_request_issuer: pulse timing, spacing, FIFO full,
// invalid drops, leak ordering and asynchronous reset.
module tb_parking_request_issuer;
  import parking_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_kind;
  logic [15:0] req_plate;
  logic [2:0]  req_floor;
  logic        hold;
  logic [15:0] license_plate;
  logic        in_mode, out_mode, leakage, err_pulse;
  logic [2:0]  leakage_floor;
  logic [7:0]  issued_cnt, dropped_cnt;
  state_t      fsm_state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pulse_total = 0;
  int err_count = 0;
  int last_start = 0;
  int prev_start = 0;
  logic [16:0] exp_q[$];

  parking_request_issuer #(.DEPTH(4), .GAP_CYCLES(6)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_kind      (req_kind),
    .req_plate     (req_plate),
    .req_floor     (req_floor),
    .hold          (hold),
    .license_plate (license_plate),
    .in_mode       (in_mode),
    .out_mode      (out_mode),
    .leakage       (leakage),
    .leakage_floor (leakage_floor),
    .err_pulse     (err_pulse),
    .issued_cnt    (issued_cnt),
    .dropped_cnt   (dropped_cnt),
    .fsm_state     (fsm_state)
  );

  // Clock and cycle counter
  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic plate_ok(input logic [15:0] p);
    return (p != 16'h0) && (p[3:0] <= 4'd9) && (p[7:4] <= 4'd9) &&
           (p[11:8] <= 4'd9) && (p[15:12] <= 4'd9);
  endfunction

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Drives one request until accepted; valid IN/OUT plates go to the scoreboard.
  task automatic push(input logic [1:0] kind, input logic [15:0] plate, input logic [2:0] flr);
    logic done;
    done = 1'b0;
    req_valid = 1'b1;
    req_kind  = kind;
    req_plate = plate;
    req_floor = flr;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clock);
      if (req_ready) begin
        @(posedge clock);
        #1;
        done = 1'b1;
      end
    end
    req_valid = 1'b0;
    if (!done) check("push_timeout", 32'd0, 32'd1);
    else if ((kind == KIND_IN || kind == KIND_OUT) && plate_ok(plate))
      exp_q.push_back({kind == KIND_OUT, plate});
  endtask

  task automatic wait_pulse(input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clock);
      if (in_mode || out_mode) seen = 1'b1;
    end
    check(tag, 32'(seen), 32'd1);
  endtask

  // Scoreboard / protocol monitor
  always @(negedge clock) begin
    if (reset_n) begin
      check("mode_excl", 32'(in_mode & out_mode), 32'd0);
      if (in_mode || out_mode) begin
        pulse_total++;
        prev_start = last_start;
        last_start = cyc;
        if (exp_q.size() == 0) check("unexpected_pulse", 32'd1, 32'd0);
        else check("pulse", 32'({out_mode, license_plate}), 32'(exp_q.pop_front()));
      end else begin
        check("plate_idle", 32'(license_plate), 32'd0);
      end
      if (err_pulse) err_count++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic early;
    int base;
    reset_n = 1'b0; req_valid = 1'b0; req_kind = 2'd0;
    req_plate = 16'h0; req_floor = 3'd0; hold = 1'b0;
    wait_cycles(3);
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_outs", 32'({in_mode, out_mode, leakage, leakage_floor, err_pulse, license_plate}), 32'd0);
    check("rst_cnts", 32'({issued_cnt, dropped_cnt}), 32'd0);
    check("rst_state", 32'(fsm_state), 32'(ST_IDLE));
    @(negedge clock);
    reset_n = 1'b1;
    wait_cycles(1);

    // 1: single IN pulse timing
    push(KIND_IN, 16'h9423, 3'd0);
    @(negedge clock);
    check("t1_pre", 32'(in_mode), 32'd0);
    @(negedge clock);
    check("t1_pulse", 32'({in_mode, license_plate}), 32'h19423);
    @(negedge clock);
    check("t1_post", 32'(in_mode), 32'd0);
    check("t1_issued", 32'(issued_cnt), 32'd1);
    wait_cycles(10);

    // 2: back-to-back IN/OUT spacing
    push(KIND_IN, 16'h8754, 3'd0);
    push(KIND_OUT, 16'h8754, 3'd0);
    wait_cycles(25);
    check("t2_spacing", 32'(last_start - prev_start), 32'd8);
    check("t2_issued", 32'(issued_cnt), 32'd3);

    // 3: fill FIFO under hold, fifth request refused
    hold = 1'b1;
    push(KIND_IN, 16'h1001, 3'd0);
    push(KIND_IN, 16'h1002, 3'd0);
    push(KIND_OUT, 16'h1003, 3'd0);
    push(KIND_IN, 16'h1004, 3'd0);
    @(negedge clock);
    check("t3_full", 32'(req_ready), 32'd0);
    req_valid = 1'b1; req_kind = KIND_IN; req_plate = 16'h1005;
    early = 1'b0;
    repeat (3) begin
      @(negedge clock);
      if (req_ready || in_mode || out_mode) early = 1'b1;
    end
    check("t3_held", 32'(early), 32'd0);
    @(posedge clock); #1;
    req_valid = 1'b0;
    hold = 1'b0;
    wait_cycles(40);
    check("t3_issued", 32'(issued_cnt), 32'd7);
    check("t3_drained", 32'(exp_q.size()), 32'd0);

    // 4: invalid plate and floor-0 leak both dropped
    base = err_count;
    push(KIND_IN, 16'h9A23, 3'd0);
    push(KIND_LEAK_ON, 16'h0, 3'd0);
    wait_cycles(10);
    check("t4_errs", 32'(err_count - base), 32'd2);
    check("t4_dropped", 32'(dropped_cnt), 32'd2);
    check("t4_leak", 32'(leakage), 32'd0);
    check("t4_issued", 32'(issued_cnt), 32'd7);

    // 5: leak behind a pulse waits for the gap
    push(KIND_IN, 16'h1111, 3'd0);
    push(KIND_LEAK_ON, 16'h0, 3'd3);
    wait_pulse("t5_pulse_seen");
    early = 1'b0;
    repeat (7) begin
      @(negedge clock);
      if (leakage) early = 1'b1;
    end
    check("t5_leak_early", 32'(early), 32'd0);
    @(negedge clock);
    check("t5_leak_on", 32'({leakage, leakage_floor}), 32'hB);
    push(KIND_LEAK_OFF, 16'h0, 3'd0);
    wait_cycles(3);
    check("t5_leak_off", 32'({leakage, leakage_floor}), 32'h0);
    check("t5_issued", 32'(issued_cnt), 32'd8);

    // 6: async reset during GAP with entries queued
    push(KIND_IN, 16'h2001, 3'd0);
    push(KIND_IN, 16'h2002, 3'd0);
    push(KIND_IN, 16'h2003, 3'd0);
    wait_pulse("t6_pulse_seen");
    @(negedge clock);
    @(negedge clock);
    check("t6_in_gap", 32'(fsm_state), 32'(ST_GAP));
    #1 reset_n = 1'b0;
    #1;
    check("t6_rst_cnts", 32'({issued_cnt, dropped_cnt}), 32'd0);
    check("t6_rst_outs", 32'({in_mode, out_mode, leakage, err_pulse, license_plate}), 32'd0);
    check("t6_rst_ready", 32'(req_ready), 32'd1);
    check("t6_rst_state", 32'(fsm_state), 32'(ST_IDLE));
    exp_q.delete();
    wait_cycles(2);
    @(negedge clock);
    reset_n = 1'b1;
    base = pulse_total;
    wait_cycles(25);
    check("t6_no_pulses", 32'(pulse_total - base), 32'd0);
    check("t6_issued", 32'(issued_cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
